sdram_port_arbiter: RTL and testbench

- Multi-port burst scheduler in front of the SDRAM controller. It shares one burst engine between NUM_PORTS FIFO-backed ports; each port is configured at build time as either a write port or a read port.
- Per port it tracks a rolling SDRAM address window (start/max with wrap) and decides eligibility from FIFO fill level.
- Grants ports round-robin and issues one burst request (addr, length, direction) at a time, then waits for the controller's done pulse.
- Drives one-hot GRANT so the port's FIFO read/write strobe is masked to the active port only.

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_port_arbiter_rr_pick.sv | 33 +++
 rtl/sdram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM state codes, default widths
// and the round-robin index helper.
package sdram_arb_pkg;

  localparam int ASIZE_D   = 23;
  localparam int LSIZE_D   = 9;
  localparam int LVLSIZE_D = 16;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_ISSUE  = 2'd1;
  localparam arb_state_t ST_BUSY   = 2'd2;
  localparam arb_state_t ST_UPDATE = 2'd3;

  function automatic logic [2:0] next_idx(input logic [2:0] idx, input int n);
    if (int'(idx) >= n - 1) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          vld
);

  logic [2:0] start;

  // Two passes: indices at/after ptr+1 first, then the wrapped-around low part.
  always_comb begin
    start = next_idx(3'(ptr), N);
    vld   = 1'b0;
    win   = '0;
    for (int j = 0; j < N; j++)
      if (!vld && elig[j] && j >= int'(start)) begin
        vld = 1'b1;
        win = IW'(j);
      end
    for (int j = 0; j < N; j++)
      if (!vld && elig[j]) begin
        vld = 1'b1;
        win = IW'(j);
      end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port SDRAM burst scheduler: per-port rolling address windows, round-robin grant.
// Define SDRAM_ARB_WRITE_PRIORITY_EN to let eligible write ports always beat read ports.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                   NUM_PORTS  = 4,
  parameter int                   ASIZE      = ASIZE_D,
  parameter int                   LSIZE      = LSIZE_D,
  parameter int                   LVLSIZE    = LVLSIZE_D,
  parameter int                   FIFO_DEPTH = 512,
  parameter logic [NUM_PORTS-1:0] PORT_IS_WR = 4'b0011
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NUM_PORTS*ASIZE-1:0]   PORT_START_ADDR,
  input  logic [NUM_PORTS*ASIZE-1:0]   PORT_MAX_ADDR,
  input  logic [NUM_PORTS*LSIZE-1:0]   PORT_LENGTH,
  input  logic [NUM_PORTS-1:0]         PORT_LOAD,
  input  logic [NUM_PORTS*LVLSIZE-1:0] PORT_LEVEL,
  output logic                         REQ,
  output logic                         REQ_WRITE,
  output logic [ASIZE-1:0]             REQ_ADDR,
  output logic [LSIZE-1:0]             REQ_LENGTH,
  output logic [2:0]                   REQ_PORT,
  input  logic                         REQ_ACK,
  input  logic                         DONE,
  output logic [NUM_PORTS-1:0]         GRANT
);

  localparam int IW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0][ASIZE-1:0]   start_a, max_a, addr_q, adv_a;
  logic [NUM_PORTS-1:0][LSIZE-1:0]   len_a;
  logic [NUM_PORTS-1:0][LVLSIZE-1:0] lvl_a;
  logic [NUM_PORTS-1:0]              elig;

  arb_state_t    state;
  logic [IW-1:0] k;
  logic          skip_adv;
  logic [IW-1:0] pick;
  logic          pick_vld;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [LVLSIZE:0] lvl_x, len_x;
    logic [ASIZE:0]   sum;

    assign start_a[i] = PORT_START_ADDR[i*ASIZE +: ASIZE];
    assign max_a[i]   = PORT_MAX_ADDR[i*ASIZE +: ASIZE];
    assign len_a[i]   = PORT_LENGTH[i*LSIZE +: LSIZE];
    assign lvl_a[i]   = PORT_LEVEL[i*LVLSIZE +: LVLSIZE];

    assign lvl_x = {1'b0, lvl_a[i]};
    assign len_x = (LVLSIZE+1)'(len_a[i]);
    // Write ports need a full burst buffered; read ports need room for one.
    assign elig[i] = (len_a[i] != '0) && !PORT_LOAD[i] &&
                     (PORT_IS_WR[i] ? (lvl_x >= len_x)
                                    : (lvl_x + len_x <= (LVLSIZE+1)'(FIFO_DEPTH)));

    assign sum      = {1'b0, addr_q[i]} + (ASIZE+1)'(REQ_LENGTH);
    assign adv_a[i] = (max_a[i] <= start_a[i] || sum >= {1'b0, max_a[i]})
                      ? start_a[i] : sum[ASIZE-1:0];
  end

`ifdef SDRAM_ARB_WRITE_PRIORITY_EN
  logic [IW-1:0] wr_ptr, rd_ptr, wr_win, rd_win;
  logic          wr_vld, rd_vld;

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick_wr (
    .elig(elig & PORT_IS_WR), .ptr(wr_ptr), .win(wr_win), .vld(wr_vld));
  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick_rd (
    .elig(elig & ~PORT_IS_WR), .ptr(rd_ptr), .win(rd_win), .vld(rd_vld));

  assign pick     = wr_vld ? wr_win : rd_win;
  assign pick_vld = wr_vld | rd_vld;
`else
  logic [IW-1:0] ptr;

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .elig(elig), .ptr(ptr), .win(pick), .vld(pick_vld));
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      REQ        <= 1'b0;
      REQ_WRITE  <= 1'b0;
      REQ_ADDR   <= '0;
      REQ_LENGTH <= '0;
      REQ_PORT   <= '0;
      GRANT      <= '0;
      k          <= '0;
      skip_adv   <= 1'b0;
`ifdef SDRAM_ARB_WRITE_PRIORITY_EN
      wr_ptr     <= IW'(NUM_PORTS - 1);
      rd_ptr     <= IW'(NUM_PORTS - 1);
`else
      ptr        <= IW'(NUM_PORTS - 1);
`endif
    end else begin
      case (state)
        ST_IDLE: if (pick_vld) begin
          state      <= ST_ISSUE;
          k          <= pick;
          GRANT      <= NUM_PORTS'(1) << pick;
          REQ        <= 1'b1;
          REQ_ADDR   <= addr_q[pick];
          REQ_LENGTH <= len_a[pick];
          REQ_WRITE  <= PORT_IS_WR[pick];
          REQ_PORT   <= 3'(pick);
          skip_adv   <= 1'b0;
`ifdef SDRAM_ARB_WRITE_PRIORITY_EN
          if (PORT_IS_WR[pick]) wr_ptr <= pick;
          else                  rd_ptr <= pick;
`else
          ptr        <= pick;
`endif
        end
        ST_ISSUE: begin
          skip_adv <= skip_adv | PORT_LOAD[k];
          if (REQ_ACK) begin
            REQ   <= 1'b0;
            state <= DONE ? ST_UPDATE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          skip_adv <= skip_adv | PORT_LOAD[k];
          if (DONE) state <= ST_UPDATE;
        end
        default: begin
          GRANT <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A reload anywhere during the burst resets the window and cancels the advance.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q <= start_a;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (PORT_LOAD[i])
          addr_q[i] <= start_a[i];
        else if (state == ST_UPDATE && int'(k) == i && !skip_adv)
          addr_q[i] <= adv_a[i];
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a simple controller model.
module tb_sdram_port_arbiter;
  localparam int NP = 4, AS = 23, LS = 9, LV = 16;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic [NP*AS-1:0]  PORT_START_ADDR = '0;
  logic [NP*AS-1:0]  PORT_MAX_ADDR = '0;
  logic [NP*LS-1:0]  PORT_LENGTH = '0;
  logic [NP-1:0]     PORT_LOAD = '0;
  logic [NP*LV-1:0]  PORT_LEVEL = '0;
  logic              REQ, REQ_WRITE;
  logic [AS-1:0]     REQ_ADDR;
  logic [LS-1:0]     REQ_LENGTH;
  logic [2:0]        REQ_PORT;
  logic              REQ_ACK = 1'b0;
  logic              DONE = 1'b0;
  logic [NP-1:0]     GRANT;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(.NUM_PORTS(NP), .ASIZE(AS), .LSIZE(LS), .LVLSIZE(LV),
                       .FIFO_DEPTH(512), .PORT_IS_WR(4'b0011)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .PORT_START_ADDR(PORT_START_ADDR), .PORT_MAX_ADDR(PORT_MAX_ADDR),
    .PORT_LENGTH(PORT_LENGTH), .PORT_LOAD(PORT_LOAD), .PORT_LEVEL(PORT_LEVEL),
    .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_LENGTH(REQ_LENGTH),
    .REQ_PORT(REQ_PORT), .REQ_ACK(REQ_ACK), .DONE(DONE), .GRANT(GRANT));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int p, input int st, input int mx, input int len, input int lvl);
    PORT_START_ADDR[p*AS +: AS] = AS'(st);
    PORT_MAX_ADDR[p*AS +: AS]   = AS'(mx);
    PORT_LENGTH[p*LS +: LS]     = LS'(len);
    PORT_LEVEL[p*LV +: LV]      = LV'(lvl);
  endtask

  task automatic rst_begin();
    RESET_N = 1'b0;
    PORT_LENGTH = '0;
    PORT_LEVEL = '0;
    PORT_LOAD = '0;
    @(negedge CLK);
  endtask

  task automatic rst_end();
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (!REQ && n < max) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_req"}, 32'(REQ), 32'd1);
  endtask

  // One full burst: check request fields, hold a cycle, ack, optional reload, done.
  task automatic burst(input string tag, input int port, input int addr, input int len,
                       input bit wr, input bit same, input bit ld);
    wait_req(tag, 20);
    chk({tag, "_port"},  32'(REQ_PORT),   32'(port));
    chk({tag, "_addr"},  32'(REQ_ADDR),   32'(addr));
    chk({tag, "_len"},   32'(REQ_LENGTH), 32'(len));
    chk({tag, "_wr"},    32'(REQ_WRITE),  32'(wr));
    chk({tag, "_grant"}, 32'(GRANT),      32'd1 << port);
    @(negedge CLK);
    chk({tag, "_hold"},  32'(REQ),        32'd1);
    REQ_ACK = 1'b1;
    DONE = same;
    @(negedge CLK);
    REQ_ACK = 1'b0;
    DONE = 1'b0;
    chk({tag, "_reqlo"}, 32'(REQ), 32'd0);
    if (!same) begin
      if (ld) PORT_LOAD[port] = 1'b1;
      @(negedge CLK);
      PORT_LOAD = '0;
      chk({tag, "_busy"}, 32'(GRANT), 32'd1 << port);
      DONE = 1'b1;
      @(negedge CLK);
      DONE = 1'b0;
    end
    @(negedge CLK);
    chk({tag, "_idle"}, 32'(GRANT), 32'd0);
  endtask

  initial begin
    // reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_req",   32'(REQ),        32'd0);
    chk("rst_grant", 32'(GRANT),      32'd0);
    chk("rst_addr",  32'(REQ_ADDR),   32'd0);
    chk("rst_len",   32'(REQ_LENGTH), 32'd0);
    chk("rst_port",  32'(REQ_PORT),   32'd0);
    chk("rst_wr",    32'(REQ_WRITE),  32'd0);

    // single write port, window 0..1024, wraps after four bursts
    cfg(0, 0, 1024, 256, 300);
    rst_end();
    burst("t1a", 0, 0,   256, 1, 0, 0);
    burst("t1b", 0, 256, 256, 1, 0, 0);
    burst("t1c", 0, 512, 256, 1, 0, 0);
    burst("t1d", 0, 768, 256, 1, 0, 0);
    burst("t1e", 0, 0,   256, 1, 0, 0);

    // write port 0 and read port 2 alternate, independent addresses
    rst_begin();
    cfg(0, 0, 1024, 256, 300);
    cfg(2, 4096, 8192, 128, 0);
    rst_end();
    burst("t2a", 0, 0,    256, 1, 0, 0);
    burst("t2b", 2, 4096, 128, 0, 0, 0);
    burst("t2c", 0, 256,  256, 1, 0, 0);
    burst("t2d", 2, 4224, 128, 0, 1, 0);

    // read-port space boundary: 257+256 > 512 blocked, 256+256 == 512 allowed
    rst_begin();
    cfg(2, 100, 2000, 256, 257);
    rst_end();
    repeat (5) @(negedge CLK);
    chk("t3_blocked", 32'(REQ),   32'd0);
    chk("t3_nogrant", 32'(GRANT), 32'd0);
    PORT_LEVEL[2*LV +: LV] = LV'(256);
    wait_req("t3_fast", 2);
    burst("t3", 2, 100, 256, 0, 0, 0);

    // reload during BUSY cancels the advance
    rst_begin();
    cfg(0, 0, 2048, 256, 300);
    rst_end();
    burst("t4a", 0, 0,   256, 1, 0, 0);
    burst("t4b", 0, 256, 256, 1, 0, 0);
    burst("t4c", 0, 512, 256, 1, 0, 1);
    burst("t4d", 0, 0,   256, 1, 0, 0);

    // asynchronous reset mid-burst
    rst_begin();
    cfg(0, 64, 4096, 32, 100);
    rst_end();
    burst("t5a", 0, 64, 32, 1, 0, 0);
    wait_req("t5b", 20);
    chk("t5b_addr", 32'(REQ_ADDR), 32'd96);
    REQ_ACK = 1'b1;
    @(negedge CLK);
    REQ_ACK = 1'b0;
    chk("t5_busy_grant", 32'(GRANT), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("t5_async_req",   32'(REQ),   32'd0);
    chk("t5_async_grant", 32'(GRANT), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    burst("t5c", 0, 64, 32, 1, 0, 0);

    // write port 1 vs read port 3
    rst_begin();
    cfg(1, 'h1000, 'h2000, 16, 100);
    cfg(3, 'h3000, 'h4000, 16, 0);
    rst_end();
`ifdef SDRAM_ARB_WRITE_PRIORITY_EN
    burst("t6a", 1, 'h1000, 16, 1, 0, 0);
    burst("t6b", 1, 'h1010, 16, 1, 0, 0);
    burst("t6c", 1, 'h1020, 16, 1, 0, 0);
`else
    burst("t6a", 1, 'h1000, 16, 1, 0, 0);
    burst("t6b", 3, 'h3000, 16, 0, 0, 0);
    burst("t6c", 1, 'h1010, 16, 1, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
